// File: rtl/bus_arbiter_if.sv
// bus_arbiter_if: bundles the two master request channels, the shared
// memory port and the read-data return of the bus arbiter.
//   slave  modport : arbiter side (takes requests, drives grants/acks and
//                    the registered memory port, returns RDATA)
//   master modport : environment side (masters and the memory)
// Handshake: a master raises Mx_Req with ADDR/DOUT/W and holds it until
// Mx_Ack; Mx_Gnt marks ownership of the memory port, Mx_Ack is a one-cycle
// completion pulse during which RDATA carries read data.
interface bus_arbiter_if;
  logic        M0_Req;
  logic [15:0] M0_ADDR;
  logic [15:0] M0_DOUT;
  logic        M0_W;
  logic        M0_Gnt;
  logic        M0_Ack;
  logic        M1_Req;
  logic [15:0] M1_ADDR;
  logic [15:0] M1_DOUT;
  logic        M1_W;
  logic        M1_Gnt;
  logic        M1_Ack;
  logic [15:0] MEM_ADDR;
  logic [15:0] MEM_DOUT;
  logic        MEM_W;
  logic [15:0] MEM_DIN;
  logic [15:0] RDATA;

  modport slave (
    input  M0_Req, M0_ADDR, M0_DOUT, M0_W,
    input  M1_Req, M1_ADDR, M1_DOUT, M1_W,
    input  MEM_DIN,
    output M0_Gnt, M0_Ack, M1_Gnt, M1_Ack,
    output MEM_ADDR, MEM_DOUT, MEM_W, RDATA
  );

  modport master (
    output M0_Req, M0_ADDR, M0_DOUT, M0_W,
    output M1_Req, M1_ADDR, M1_DOUT, M1_W,
    output MEM_DIN,
    input  M0_Gnt, M0_Ack, M1_Gnt, M1_Ack,
    input  MEM_ADDR, MEM_DOUT, MEM_W, RDATA
  );
endinterface

// File: rtl/bus_arbiter.sv
// bus_arbiter: two-master round-robin arbiter in front of a single
// synchronous memory port. Each transaction takes IDLE -> ACCESS -> RESP,
// so a request seen in IDLE at cycle N is acknowledged at cycle N+2.
// Ports:
//   Clock      rising-edge clock
//   Resetn     synchronous active-low reset
//   bus        bus_arbiter_if.slave (requests, grants, acks, memory port)
//   dbg_state  current FSM state (00 IDLE, 01 ACCESS, 10 RESP)
module bus_arbiter (
  input  logic                Clock,
  input  logic                Resetn,
  bus_arbiter_if.slave        bus,
  output logic [1:0]          dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_t;

  state_t      state;
  logic        rr_ptr;    // master favoured when both request
  logic        owner;     // master that won the current transaction
  logic        mem_w_q;
  logic [15:0] mem_addr;
  logic [15:0] mem_dout;
  logic        m0_gnt;
  logic        m0_ack;
  logic        m1_gnt;
  logic        m1_ack;
  logic        winner;

  always_comb begin
    winner = 1'b0;
    if (bus.M0_Req && bus.M1_Req) winner = rr_ptr;
    else if (bus.M1_Req)          winner = 1'b1;
  end

  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      state    <= IDLE;
      rr_ptr   <= 1'b0;
      owner    <= 1'b0;
      mem_w_q  <= 1'b0;
      mem_addr <= '0;
      mem_dout <= '0;
      m0_gnt   <= 1'b0;
      m0_ack   <= 1'b0;
      m1_gnt   <= 1'b0;
      m1_ack   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          m0_gnt  <= 1'b0;
          m1_gnt  <= 1'b0;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
          mem_w_q <= 1'b0;
          if (bus.M0_Req || bus.M1_Req) begin
            state    <= ACCESS;
            owner    <= winner;
            rr_ptr   <= ~winner;
            m0_gnt   <= ~winner;
            m1_gnt   <= winner;
            mem_addr <= winner ? bus.M1_ADDR : bus.M0_ADDR;
            mem_dout <= winner ? bus.M1_DOUT : bus.M0_DOUT;
            mem_w_q  <= winner ? bus.M1_W    : bus.M0_W;
          end
        end
        ACCESS: begin
          // Memory samples the write on this edge; drop it so every write
          // is exactly one cycle wide.
          state   <= RESP;
          mem_w_q <= 1'b0;
          m0_ack  <= ~owner;
          m1_ack  <= owner;
        end
        RESP: begin
          state  <= IDLE;
          m0_gnt <= 1'b0;
          m1_gnt <= 1'b0;
          m0_ack <= 1'b0;
          m1_ack <= 1'b0;
        end
        default: begin
          state   <= IDLE;
          mem_w_q <= 1'b0;
          m0_gnt  <= 1'b0;
          m1_gnt  <= 1'b0;
          m0_ack  <= 1'b0;
          m1_ack  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.M0_Gnt   = m0_gnt;
  assign bus.M0_Ack   = m0_ack;
  assign bus.M1_Gnt   = m1_gnt;
  assign bus.M1_Ack   = m1_ack;
  assign bus.MEM_ADDR = mem_addr;
  assign bus.MEM_DOUT = mem_dout;
  // The memory samples MEM_W on the very edge that also applies a reset
  // asserted during ACCESS; masking with Resetn keeps an aborted write
  // from landing in memory.
  assign bus.MEM_W    = mem_w_q & Resetn;
  assign bus.RDATA    = bus.MEM_DIN;
  assign dbg_state    = state;

endmodule

// File: tb/tb_bus_arbiter.sv
module tb_bus_arbiter;
  logic       Clock = 1'b0;
  logic       Resetn;
  logic [1:0] dbg_state;
  int         errors = 0;
  int         checks = 0;

  bus_arbiter_if bus();

  bus_arbiter dut (
    .Clock     (Clock),
    .Resetn    (Resetn),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  always #5 Clock = ~Clock;

  // Synchronous memory: read data appears the cycle after the address.
  logic [15:0] mem [0:255];
  logic        clr;
  logic        pre_we;
  logic [7:0]  pre_addr;
  logic [15:0] pre_data;

  always @(posedge Clock) begin
    if (clr) begin
      for (int i = 0; i < 256; i++) mem[i] <= '0;
    end else begin
      if (pre_we)    mem[pre_addr] <= pre_data;
      if (bus.MEM_W) mem[bus.MEM_ADDR[7:0]] <= bus.MEM_DOUT;
    end
    bus.MEM_DIN <= mem[bus.MEM_ADDR[7:0]];
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic clear_masters();
    bus.M0_Req = 0; bus.M0_ADDR = '0; bus.M0_DOUT = '0; bus.M0_W = 0;
    bus.M1_Req = 0; bus.M1_ADDR = '0; bus.M1_DOUT = '0; bus.M1_W = 0;
  endtask

  task automatic do_reset();
    Resetn = 0; clr = 1;
    step(); step();
    Resetn = 1; clr = 0;
  endtask

  task automatic preload(input logic [7:0] ad, input logic [15:0] dt);
    pre_we = 1; pre_addr = ad; pre_data = dt;
    step();
    pre_we = 0;
  endtask

  task automatic test_reset();
    clear_masters();
    bus.M0_Req = 1;        // reset must win over a pending request
    Resetn = 0; clr = 1;
    step(); step();
    checks++; if ({bus.M0_Gnt, bus.M1_Gnt, bus.M0_Ack, bus.M1_Ack} !== 4'b0) begin
      errors++; $display("FAIL reset_gnt_ack: got %b want 0000", {bus.M0_Gnt, bus.M1_Gnt, bus.M0_Ack, bus.M1_Ack}); end
    checks++; if (bus.MEM_W !== 1'b0 || bus.MEM_ADDR !== 16'h0 || bus.MEM_DOUT !== 16'h0) begin
      errors++; $display("FAIL reset_mem: got w=%b a=%h d=%h want 0/0000/0000", bus.MEM_W, bus.MEM_ADDR, bus.MEM_DOUT); end
    checks++; if (dbg_state !== 2'b00) begin
      errors++; $display("FAIL reset_state: got %b want 00", dbg_state); end
    Resetn = 1; clr = 0; bus.M0_Req = 0;
    step();
  endtask

  task automatic test_m0_read();
    preload(8'h10, 16'hBEEF);
    bus.M0_Req = 1; bus.M0_ADDR = 16'h0010; bus.M0_W = 0;
    step();
    checks++; if (bus.M0_Gnt !== 1 || bus.M1_Gnt !== 0 || bus.MEM_ADDR !== 16'h0010 || bus.MEM_W !== 0 || bus.M0_Ack !== 0) begin
      errors++; $display("FAIL m0_read_access: got g0=%b g1=%b a=%h w=%b k=%b want 1 0 0010 0 0",
                         bus.M0_Gnt, bus.M1_Gnt, bus.MEM_ADDR, bus.MEM_W, bus.M0_Ack); end
    step();
    checks++; if (bus.M0_Ack !== 1 || bus.M1_Ack !== 0 || bus.RDATA !== 16'hBEEF) begin
      errors++; $display("FAIL m0_read_ack: got k0=%b k1=%b rdata=%h want 1 0 beef", bus.M0_Ack, bus.M1_Ack, bus.RDATA); end
    bus.M0_Req = 0;
    step();
    checks++; if (bus.M0_Gnt !== 0 || bus.M0_Ack !== 0 || dbg_state !== 2'b00) begin
      errors++; $display("FAIL m0_read_idle: got g0=%b k0=%b st=%b want 0 0 00", bus.M0_Gnt, bus.M0_Ack, dbg_state); end
  endtask

  task automatic test_m1_write();
    bus.M1_Req = 1; bus.M1_ADDR = 16'h0020; bus.M1_DOUT = 16'h1234; bus.M1_W = 1;
    step();
    checks++; if (bus.MEM_W !== 1 || bus.M1_Gnt !== 1 || bus.MEM_ADDR !== 16'h0020 || bus.MEM_DOUT !== 16'h1234) begin
      errors++; $display("FAIL m1_write_access: got w=%b g1=%b a=%h d=%h want 1 1 0020 1234",
                         bus.MEM_W, bus.M1_Gnt, bus.MEM_ADDR, bus.MEM_DOUT); end
    step();
    checks++; if (bus.MEM_W !== 0 || bus.M1_Ack !== 1) begin
      errors++; $display("FAIL m1_write_resp: got w=%b k1=%b want 0 1", bus.MEM_W, bus.M1_Ack); end
    bus.M1_Req = 0;
    step();
    checks++; if (bus.MEM_ADDR !== 16'h0020 || bus.MEM_DOUT !== 16'h1234 || bus.MEM_W !== 0) begin
      errors++; $display("FAIL idle_hold: got a=%h d=%h w=%b want 0020 1234 0", bus.MEM_ADDR, bus.MEM_DOUT, bus.MEM_W); end
    bus.M1_Req = 1; bus.M1_W = 0;
    step(); step();
    checks++; if (bus.M1_Ack !== 1 || bus.RDATA !== 16'h1234) begin
      errors++; $display("FAIL m1_readback: got k1=%b rdata=%h want 1 1234", bus.M1_Ack, bus.RDATA); end
    bus.M1_Req = 0;
    step();
  endtask

  task automatic test_round_robin();
    do_reset();
    clear_masters();
    bus.M0_Req = 1; bus.M0_ADDR = 16'h0001;
    bus.M1_Req = 1; bus.M1_ADDR = 16'h0002;
    for (int k = 0; k < 12; k++) begin
      logic [1:0] eg, ea;
      int who;
      who = (k / 3) % 2;     // slot order M0, M1, M0, M1
      eg = 2'b00; ea = 2'b00;
      if (k % 3 != 0) eg = (who == 0) ? 2'b01 : 2'b10;
      if (k % 3 == 2) ea = (who == 0) ? 2'b01 : 2'b10;
      checks++; if ({bus.M1_Gnt, bus.M0_Gnt} !== eg || {bus.M1_Ack, bus.M0_Ack} !== ea) begin
        errors++; $display("FAIL rr_cycle%0d: got gnt=%b ack=%b want gnt=%b ack=%b",
                           k, {bus.M1_Gnt, bus.M0_Gnt}, {bus.M1_Ack, bus.M0_Ack}, eg, ea); end
      step();
    end
    clear_masters();
    step();
  endtask

  task automatic test_addr_change();
    preload(8'h30, 16'h3030);
    preload(8'h40, 16'h4040);
    bus.M1_Req = 1; bus.M1_ADDR = 16'h0030; bus.M1_W = 0;
    step();
    bus.M1_ADDR = 16'h0040; bus.M1_W = 1; bus.M1_DOUT = 16'hAAAA;
    checks++; if (bus.MEM_ADDR !== 16'h0030 || bus.MEM_W !== 0) begin
      errors++; $display("FAIL addr_change_access: got a=%h w=%b want 0030 0", bus.MEM_ADDR, bus.MEM_W); end
    step();
    checks++; if (bus.M1_Ack !== 1 || bus.MEM_ADDR !== 16'h0030 || bus.RDATA !== 16'h3030 || bus.MEM_W !== 0) begin
      errors++; $display("FAIL addr_change_resp: got k1=%b a=%h rdata=%h w=%b want 1 0030 3030 0",
                         bus.M1_Ack, bus.MEM_ADDR, bus.RDATA, bus.MEM_W); end
    clear_masters();
    step();
  endtask

  task automatic test_reset_abort();
    preload(8'h50, 16'h5555);
    bus.M0_Req = 1; bus.M0_ADDR = 16'h0050; bus.M0_DOUT = 16'hDEAD; bus.M0_W = 1;
    step();
    checks++; if (bus.MEM_W !== 1 || bus.M0_Gnt !== 1) begin
      errors++; $display("FAIL abort_access: got w=%b g0=%b want 1 1", bus.MEM_W, bus.M0_Gnt); end
    Resetn = 0; clear_masters();
    #1;
    checks++; if (bus.MEM_W !== 0) begin
      errors++; $display("FAIL abort_memw: got %b want 0", bus.MEM_W); end
    step();
    Resetn = 1;
    for (int k = 0; k < 4; k++) begin
      checks++; if ({bus.M0_Gnt, bus.M0_Ack, bus.M1_Gnt, bus.M1_Ack, bus.MEM_W} !== 5'b0) begin
        errors++; $display("FAIL abort_quiet%0d: got g0 k0 g1 k1 w=%b want 00000", k,
                           {bus.M0_Gnt, bus.M0_Ack, bus.M1_Gnt, bus.M1_Ack, bus.MEM_W}); end
      step();
    end
    bus.M0_Req = 1; bus.M0_ADDR = 16'h0050; bus.M0_W = 0;
    step(); step();
    checks++; if (bus.M0_Ack !== 1 || bus.RDATA !== 16'h5555) begin
      errors++; $display("FAIL abort_word: got k0=%b rdata=%h want 1 5555", bus.M0_Ack, bus.RDATA); end
    clear_masters();
    step();
  endtask

  task automatic test_pulse_withdraw();
    bus.M1_Req = 1; bus.M1_ADDR = 16'h0030; bus.M1_W = 0;
    step();
    bus.M0_Req = 1; bus.M0_ADDR = 16'h0010; bus.M0_W = 1; bus.M0_DOUT = 16'h0BAD;
    step();
    bus.M0_Req = 0;
    checks++; if (bus.M1_Ack !== 1 || bus.M0_Gnt !== 0 || bus.M0_Ack !== 0) begin
      errors++; $display("FAIL pulse_resp: got k1=%b g0=%b k0=%b want 1 0 0", bus.M1_Ack, bus.M0_Gnt, bus.M0_Ack); end
    bus.M1_Req = 0;
    for (int k = 0; k < 4; k++) begin
      step();
      checks++; if (bus.M0_Gnt !== 0 || bus.M0_Ack !== 0 || bus.MEM_W !== 0) begin
        errors++; $display("FAIL pulse_quiet%0d: got g0=%b k0=%b w=%b want 0 0 0", k, bus.M0_Gnt, bus.M0_Ack, bus.MEM_W); end
    end
    clear_masters();
  endtask

  // Random traffic against a transaction-level model: the arbiter is free
  // every third cycle after a grant, the winner follows round-robin rules,
  // and the ack arrives two cycles after the winning request.
  task automatic test_random();
    logic [33:0] exp_q[$];     // {master, write, addr, data}
    int          start_q[$];
    logic [15:0] ref_mem [0:255];
    logic        busy[2], wr[2], prev_ack[2];
    logic [15:0] ad[2], dt[2];
    logic [15:0] last_addr, last_dout;
    int          free_at, ptr, cyc;

    do_reset();
    clear_masters();
    for (int i = 0; i < 256; i++) ref_mem[i] = '0;
    for (int m = 0; m < 2; m++) begin busy[m] = 0; wr[m] = 0; ad[m] = '0; dt[m] = '0; prev_ack[m] = 0; end
    last_addr = '0; last_dout = '0; free_at = 0; ptr = 0; cyc = 0;

    for (int n = 0; n < 400; n++) begin
      logic gnt_now[2];
      logic [1:0] eg, ea;
      logic ew;
      step(); cyc++;
      gnt_now[0] = bus.M0_Gnt; gnt_now[1] = bus.M1_Gnt;
      for (int m = 0; m < 2; m++) begin
        if (prev_ack[m]) busy[m] = 0;
        if (busy[m] && !gnt_now[m] && $urandom_range(0, 9) == 0) busy[m] = 0;
        else if (busy[m] && gnt_now[m] && $urandom_range(0, 1) == 1) begin
          ad[m] = 16'($urandom_range(0, 15)); dt[m] = 16'($urandom); wr[m] = 1'($urandom_range(0, 1));
        end
        if (!busy[m] && n < 350 && $urandom_range(0, 2) == 0) begin
          busy[m] = 1; ad[m] = 16'($urandom_range(0, 15)); dt[m] = 16'($urandom); wr[m] = 1'($urandom_range(0, 1));
        end
      end
      bus.M0_Req = busy[0]; bus.M0_ADDR = ad[0]; bus.M0_DOUT = dt[0]; bus.M0_W = wr[0];
      bus.M1_Req = busy[1]; bus.M1_ADDR = ad[1]; bus.M1_DOUT = dt[1]; bus.M1_W = wr[1];

      eg = 2'b00; ea = 2'b00; ew = 0;
      if (exp_q.size() > 0) begin
        logic [33:0] e;
        e = exp_q[0];
        if (cyc == start_q[0] + 1) begin
          eg = e[33] ? 2'b10 : 2'b01; ew = e[32];
        end
        if (cyc == start_q[0] + 2) begin
          eg = e[33] ? 2'b10 : 2'b01; ea = eg;
          if (!e[32]) begin
            checks++; if (bus.RDATA !== ref_mem[e[23:16]]) begin
              errors++; $display("FAIL rand_rdata c%0d: got %h want %h", cyc, bus.RDATA, ref_mem[e[23:16]]); end
          end else ref_mem[e[23:16]] = e[15:0];
          void'(exp_q.pop_front()); void'(start_q.pop_front());
        end
      end
      checks++; if ({bus.M1_Gnt, bus.M0_Gnt} !== eg || {bus.M1_Ack, bus.M0_Ack} !== ea || bus.MEM_W !== ew) begin
        errors++; $display("FAIL rand_ctrl c%0d: got gnt=%b ack=%b w=%b want gnt=%b ack=%b w=%b", cyc,
                           {bus.M1_Gnt, bus.M0_Gnt}, {bus.M1_Ack, bus.M0_Ack}, bus.MEM_W, eg, ea, ew); end
      checks++; if (bus.MEM_ADDR !== last_addr || bus.MEM_DOUT !== last_dout) begin
        errors++; $display("FAIL rand_port c%0d: got a=%h d=%h want a=%h d=%h", cyc,
                           bus.MEM_ADDR, bus.MEM_DOUT, last_addr, last_dout); end
      prev_ack[0] = bus.M0_Ack; prev_ack[1] = bus.M1_Ack;

      if (cyc >= free_at && (busy[0] || busy[1])) begin
        int win;
        win = (busy[0] && busy[1]) ? ptr : (busy[1] ? 1 : 0);
        exp_q.push_back({1'(win), wr[win], ad[win], dt[win]});
        start_q.push_back(cyc);
        free_at = cyc + 3;
        ptr = 1 - win;
        last_addr = ad[win]; last_dout = dt[win];
      end
    end
    checks++; if (exp_q.size() != 0) begin
      errors++; $display("FAIL rand_drain: got %0d outstanding want 0", exp_q.size()); end
    clear_masters();
    step();
  endtask

  initial begin
    Resetn = 0; clr = 1; pre_we = 0; pre_addr = '0; pre_data = '0;
    clear_masters();
    test_reset();
    test_m0_read();
    test_m1_write();
    test_round_robin();
    test_addr_change();
    test_reset_abort();
    test_pulse_withdraw();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
